vx_ibuffer_issue_sched: RTL and testbench

VX_IBUFFER_ISSUE_SCHED -- requirements
Module: VX_ibuffer_issue_sched

---
 rtl/vx_gpu_pkg.sv | 19 +
 rtl/vx_ibuffer_rr_pick.sv | 35 +++
 rtl/vx_ibuffer_issue_sched.sv | 100 ++++++++++
 tb/tb_vx_ibuffer_issue_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vx_gpu_pkg.sv
// Shared GPU types and constants used by the issue front end.
// ibuffer_t is the per-warp decoded instruction entry held in the ibuffer.
package vx_gpu_pkg;

  localparam int NUM_WARPS_DEFAULT = 4;
  localparam int NW_BITS_DEFAULT   = $clog2(NUM_WARPS_DEFAULT);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wb;
  } ibuffer_t;

  localparam int IBUF_WIDTH = $bits(ibuffer_t);

endpackage

// File: rtl/vx_ibuffer_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// grant and the first set candidate bit wins.
module vx_ibuffer_rr_pick
  import vx_gpu_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEFAULT,
  parameter int NW_WIDTH  = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] cand,
  input  logic [NW_WIDTH-1:0]  last_gnt,
  output logic [NUM_WARPS-1:0] gnt_onehot,
  output logic [NW_WIDTH-1:0]  gnt_idx,
  output logic                 gnt_any
);

  logic [NW_WIDTH-1:0] idx_s;
  logic                hit_s;

  // Walk the warps in rotated order; NUM_WARPS is a power of two so the
  // index addition wraps without an explicit modulo.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    idx_s      = '0;
    hit_s      = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx_s   = last_gnt + NW_WIDTH'(i);
      hit_s   = !gnt_any && cand[idx_s];
      gnt_idx = hit_s ? idx_s : gnt_idx;
      gnt_any = gnt_any | hit_s;
    end
    gnt_onehot = gnt_any ? (NUM_WARPS'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/vx_ibuffer_issue_sched.sv
// Issue scheduler: round-robin pops one eligible per-warp ibuffer entry into
// a single-entry output register, with issue/stall performance counters.
module vx_ibuffer_issue_sched
  import vx_gpu_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEFAULT,
  parameter int NW_WIDTH  = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_WARPS-1:0]  in_valid,
  input  ibuffer_t [NUM_WARPS-1:0] in_data,
  output logic [NUM_WARPS-1:0]  in_ready,
  input  logic [NUM_WARPS-1:0]  warp_mask,
  output logic                  out_valid,
  output ibuffer_t              out_data,
  output logic [NW_WIDTH-1:0]   out_wid,
  input  logic                  out_ready,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stalls
);

  logic [NUM_WARPS-1:0] cand_s;
  logic [NUM_WARPS-1:0] gnt_onehot_s;
  logic [NW_WIDTH-1:0]  gnt_idx_s;
  logic                 gnt_any_s;
  logic                 load_en_s;
  logic                 pop_s;

  logic                 out_valid_r;
  ibuffer_t             out_data_r;
  logic [NW_WIDTH-1:0]  out_wid_r;
  logic [NW_WIDTH-1:0]  last_gnt_r;
  logic [31:0]          perf_issued_r;
  logic [31:0]          perf_stalls_r;

  vx_ibuffer_rr_pick #(
    .NUM_WARPS (NUM_WARPS),
    .NW_WIDTH  (NW_WIDTH)
  ) u_rr_pick (
    .cand       (cand_s),
    .last_gnt   (last_gnt_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s)
  );

  // Pop strobes are suppressed while the output is stalled or reset is held,
  // so a held entry is never overwritten and nothing is lost on reset.
  always_comb begin
    cand_s    = in_valid & warp_mask;
    load_en_s = !out_valid_r || out_ready;
    if (load_en_s && reset) begin
      in_ready = gnt_onehot_s;
      pop_s    = gnt_any_s;
    end else begin
      in_ready = '0;
      pop_s    = 1'b0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_wid_r   <= '0;
      last_gnt_r  <= NW_WIDTH'(NUM_WARPS - 1);
    end else if (load_en_s) begin
      out_valid_r <= pop_s;
      if (pop_s) begin
        out_data_r <= in_data[gnt_idx_s];
        out_wid_r  <= gnt_idx_s;
        last_gnt_r <= gnt_idx_s;
      end
    end
  end

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued_r <= 32'd0;
      perf_stalls_r <= 32'd0;
    end else begin
      if (out_valid_r && out_ready) begin
        perf_issued_r <= perf_issued_r + 32'd1;
      end
      if (out_valid_r && !out_ready) begin
        perf_stalls_r <= perf_stalls_r + 32'd1;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_wid     = out_wid_r;
  assign perf_issued = perf_issued_r;
  assign perf_stalls = perf_stalls_r;

endmodule

// File: tb/tb_vx_ibuffer_issue_sched.sv
// Directed self-checking bench for vx_ibuffer_issue_sched (4 warps).
module tb_vx_ibuffer_issue_sched;
  import vx_gpu_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     in_valid;
  ibuffer_t [3:0] in_data;
  logic [3:0]     in_ready;
  logic [3:0]     warp_mask;
  logic           out_valid;
  ibuffer_t       out_data;
  logic [1:0]     out_wid;
  logic           out_ready;
  logic [31:0]    perf_issued;
  logic [31:0]    perf_stalls;

  int n_cmp = 0;
  int n_err = 0;

  vx_ibuffer_issue_sched #(.NUM_WARPS(4), .NW_WIDTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .warp_mask   (warp_mask),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_wid     (out_wid),
    .out_ready   (out_ready),
    .perf_issued (perf_issued),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ibuffer_t mk(input int w);
    ibuffer_t e;
    e.pc      = 32'h0000_1000 + 32'(w * 4);
    e.op_type = 4'(w + 1);
    e.rd      = 5'(w + 3);
    e.rs1     = 5'(w + 7);
    e.rs2     = 5'(w + 11);
    e.wb      = 1'b1;
    return e;
  endfunction

  initial begin
    for (int w = 0; w < 4; w++) in_data[w] = mk(w);
    reset     = 1'b0;
    in_valid  = 4'b1111;
    warp_mask = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid",  64'(out_valid),   64'd0);
    chk("rst_wid",    64'(out_wid),     64'd0);
    chk("rst_data",   64'(out_data),    64'd0);
    chk("rst_issued", 64'(perf_issued), 64'd0);
    chk("rst_stalls", 64'(perf_stalls), 64'd0);
    chk("rst_rdy",    64'(in_ready),    64'd0);

    // Round-robin over all four warps.
    reset = 1'b1;
    #1;
    chk("first_gnt", 64'(in_ready), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_wid",   64'(out_wid),   64'(k % 4));
      chk("rr_data",  64'(out_data),  64'(mk(k % 4)));
      chk("rr_rdy",   64'(in_ready),  64'(4'b0001 << ((k + 1) % 4)));
    end
    @(negedge clk); #1;
    chk("issued5", 64'(perf_issued), 64'd5);
    chk("wid1",    64'(out_wid),     64'd1);
    @(negedge clk); #1;
    chk("wid2",    64'(out_wid),     64'd2);
    chk("issued6", 64'(perf_issued), 64'd6);

    // Stall with warp 2 held; its mask drop must not disturb the entry.
    out_ready = 1'b0;
    warp_mask = 4'b1011;
    #1;
    chk("stall_rdy0", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_wid",   64'(out_wid),   64'd2);
      chk("stall_data",  64'(out_data),  64'(mk(2)));
      chk("stall_rdy",   64'(in_ready),  64'd0);
    end
    chk("stalls3",       64'(perf_stalls), 64'd3);
    chk("issued_stall",  64'(perf_issued), 64'd6);

    // Reset in the middle of the stall.
    reset = 1'b0;
    #1;
    chk("mrst_valid",  64'(out_valid),   64'd0);
    chk("mrst_wid",    64'(out_wid),     64'd0);
    chk("mrst_issued", 64'(perf_issued), 64'd0);
    chk("mrst_stalls", 64'(perf_stalls), 64'd0);
    chk("mrst_rdy",    64'(in_ready),    64'd0);
    warp_mask = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("mrst_rdy_hold", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_gnt", 64'(in_ready), 64'b0001);

    // After warp 0, cand=1001 must pick warp 3, then wrap back to warp 0.
    @(negedge clk); #1;
    chk("g0_wid", 64'(out_wid), 64'd0);
    in_valid = 4'b1001;
    #1;
    chk("rr_skip", 64'(in_ready), 64'b1000);
    @(negedge clk); #1;
    chk("g3_wid",   64'(out_wid),  64'd3);
    chk("wrap_gnt", 64'(in_ready), 64'b0001);
    @(negedge clk); #1;
    chk("wrap_wid", 64'(out_wid), 64'd0);

    // Only warp 1 eligible; warp 3 valid but masked.
    in_valid  = 4'b1010;
    warp_mask = 4'b0010;
    #1;
    chk("only1_first", 64'(in_ready), 64'b0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("only1_valid", 64'(out_valid), 64'd1);
      chk("only1_wid",   64'(out_wid),   64'd1);
      chk("only1_rdy",   64'(in_ready),  64'b0010);
    end

    // Idle: output drains and the pointer holds at warp 1.
    in_valid = 4'b0000;
    #1;
    chk("idle_rdy", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    chk("idle_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid  = 4'b1111;
    warp_mask = 4'b1111;
    #1;
    chk("idle_keep", 64'(in_ready), 64'b0100);
    @(negedge clk); #1;
    chk("after_idle_wid", 64'(out_wid), 64'd2);

    // Issue counter wrap.
    force dut.perf_issued_r = 32'hFFFF_FFFF;
    #1;
    release dut.perf_issued_r;
    @(negedge clk); #1;
    chk("issued_wrap", 64'(perf_issued), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
